// File: rtl/spread_pkg.sv
// spread_pkg: shared types and constants for the spread_word DSSS spreader.
//   - state_t        : spreader FSM states (IDLE, RUN)
//   - DEF_CODE       : default 24-chip fixed spreading code
//   - DEF_LFSR_POLY  : default Galois feedback taps for the optional LFSR code
//   - DEF_LFSR_SEED  : default (non-zero) LFSR seed
//   - chip_cnt_w()   : width of the chip counter for a given SPREAD
//   - bit_cnt_w()    : width of the bit counter for a given DATA_W
package spread_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [23:0] DEF_CODE      = 24'hA5C3F1;
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // One spare state beyond the top count keeps the counter clear of overflow.
  function automatic int chip_cnt_w(input int spread);
    return $clog2(spread + 1);
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spread_lfsr.sv
// spread_lfsr: right-shifting Galois LFSR that supplies the spreading code
// when the build defines SPREAD_LFSR_EN.
// Ports:
//   i_clk  : clock
//   i_load : load SEED this edge (has priority over i_step)
//   i_step : advance one position this edge
//   o_out  : LFSR output bit of the state the register holds after this edge,
//            so the caller can register a chip together with the LFSR state
//            that produced it.
module spread_lfsr
  import spread_pkg::*;
#(
  parameter int          W    = 16,
  parameter logic [W-1:0] POLY = DEF_LFSR_POLY,
  parameter logic [W-1:0] SEED = DEF_LFSR_SEED
) (
  input  logic i_clk,
  input  logic i_load,
  input  logic i_step,
  output logic o_out
);

  logic [W-1:0] r_lfsr;
  logic [W-1:0] w_adv;
  logic [W-1:0] w_next;

  // Galois form: shift right, fold POLY in when the bit shifted out is 1.
  assign w_adv  = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
  assign w_next = i_load ? SEED : (i_step ? w_adv : r_lfsr);
  assign o_out  = w_next[0];

  always_ff @(posedge i_clk) begin
    r_lfsr <= w_next;
  end

endmodule

// File: rtl/spread_word.sv
// spread_word: DSSS spreader. Accepts DATA_W-bit words, serialises them into
// bits (MSB or LSB first) and expands each bit into SPREAD chips by XOR with a
// spreading code. Chips leave on a 1-bit stream with full backpressure.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid never depends on ready, and a presented beat (data, last) holds
// stable until it transfers. o_ready is combinational from i_ready and i_reset
// so a new word can be taken in the same cycle the final chip leaves.
//
// Ports:
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_data, i_valid, o_ready : word input
//   o_data, o_valid, i_ready : chip output
//   o_last                 : current chip is the final chip of the word
//   o_state                : FSM state, for observation
//
// Build option: define SPREAD_LFSR_EN to take the code chip from a Galois
// LFSR (reloaded with LFSR_SEED on reset and on each accepted word, stepped
// once per chip transfer) instead of the fixed CODE.
module spread_word
  import spread_pkg::*;
#(
  parameter int                SPREAD    = 24,
  parameter int                DATA_W    = 8,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [SPREAD-1:0] CODE      = DEF_CODE,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output state_t            o_state
);

  localparam int CW = chip_cnt_w(SPREAD);
  localparam int BW = bit_cnt_w(DATA_W);
  localparam logic [CW-1:0] CHIP_MAX = CW'(SPREAD - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CW-1:0]     r_chip_cnt;
  logic [CW-1:0]     w_chip_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_nxt;
  logic              r_data;
  logic              r_valid;
  logic              r_last;
  logic              w_data_nxt;
  logic              w_valid_nxt;
  logic              w_last_nxt;

  logic              w_xfer;
  logic              w_word_end;
  logic              w_accept;
  logic              w_cur_bit;
  logic              w_code_chip;

  assign w_xfer     = r_valid && i_ready;
  assign w_word_end = w_xfer && r_last;
  assign o_ready    = !i_reset && ((r_state == IDLE) || w_word_end);
  assign w_accept   = i_valid && o_ready;

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_state = r_state;

  // Next-state: counters and shift register describe the chip that will be
  // presented after this edge; they move only on accept or chip transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_chip_nxt  = r_chip_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_valid_nxt = r_valid;
    if (w_accept) begin
      w_state_nxt = RUN;
      w_shift_nxt = i_data;
      w_chip_nxt  = '0;
      w_bit_nxt   = '0;
      w_valid_nxt = 1'b1;
    end else if (w_word_end) begin
      w_state_nxt = IDLE;
      w_valid_nxt = 1'b0;
    end else if (w_xfer) begin
      if (r_chip_cnt == CHIP_MAX) begin
        w_chip_nxt  = '0;
        w_bit_nxt   = r_bit_cnt + 1'b1;
        // The bit being sent always sits at the outgoing end of the register.
        w_shift_nxt = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      end else begin
        w_chip_nxt = r_chip_cnt + 1'b1;
      end
    end
  end

  assign w_cur_bit = MSB_FIRST ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];

`ifdef SPREAD_LFSR_EN
  spread_lfsr #(
    .W    (LFSR_W),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_load (i_reset || w_accept),
    .i_step (w_xfer),
    .o_out  (w_code_chip)
  );
`else
  logic [CW-1:0] w_code_idx;

  // Chip k of a bit uses CODE[SPREAD-1-k]: the code is read MSB first.
  assign w_code_idx  = CHIP_MAX - w_chip_nxt;
  assign w_code_chip = CODE[w_code_idx];
`endif

  assign w_data_nxt = w_valid_nxt && (w_cur_bit ^ w_code_chip);
  assign w_last_nxt = w_valid_nxt && (w_chip_nxt == CHIP_MAX) && (w_bit_nxt == BIT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_chip_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_chip_cnt <= w_chip_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
    end
  end

endmodule
